gpio_in_cond: RTL and testbench
===============================

// Module: gpio_in_cond
// PURPOSE
// - Input-conditioning and interrupt-detect stage between the gpio_if pins and the GPIO register file.
// - Synchronises asynchronous pad inputs and optionally debounces them; result feeds GPIO_PADIN.
// - Detects per-pin edge or level events, holds them as sticky GPIO_INTSTATUS bits and drives irq_o.
// PARAMETERS
// - GPIO_NUM     8   number of pins; must match gpio_if GPIO_NUM.
// - SYNC_STAGES  2   synchroniser depth; legal range 2..4.
// - DBNC_CNT_W   16  debounce threshold/counter width; used only with GPIO_DEBOUNCE_EN.
// PORTS
// - clk_i        in   1           block clock.
// - rst_n_i      in   1           asynchronous, active-low reset.
// - gpio_in_i    in   GPIO_NUM    raw pad inputs, asynchronous to clk_i.
// - inten_i      in   GPIO_NUM    per-pin interrupt enable (GPIO_INTEN).
// - inttype0_i   in   GPIO_NUM    interrupt type bit 0 (GPIO_INTTYPE0).
// - inttype1_i   in   GPIO_NUM    interrupt type bit 1 (GPIO_INTTYPE1).
// - stat_clr_i   in   1           one-cycle pulse on an APB read of GPIO_INTSTATUS.
// - dbnc_cnt_i   in   DBNC_CNT_W  debounce threshold in cycles; present only with GPIO_DEBOUNCE_EN.
// - gpio_val_o   out  GPIO_NUM    conditioned pin value (GPIO_PADIN).
// - intstatus_o  out  GPIO_NUM    sticky interrupt status (GPIO_INTSTATUS).
// - irq_o        out  1           interrupt request, OR of intstatus_o.
// BEHAVIOUR
// - Reset: all synchroniser flops, prev-value regs, status, counters = 0; gpio_val_o=0, intstatus_o=0, irq_o=0.
// - Sync: SYNC_STAGES flops per pin; gpio_val_o is valid SYNC_STAGES rising edges after a pin change (no debounce).
// - Type {inttype1,inttype0}: 00 rising edge, 01 falling edge, 10 level high, 11 level low.
// - Edge detect compares gpio_val_o against a one-cycle-delayed copy, prev_q.
// - Arm counter: edge events are suppressed until SYNC_STAGES+1 cycles after reset release, so a pin held high through reset gives no rising event.
// - Arm counter saturates; level events are not suppressed.
// - Status set: status[i] <= 1 when event[i] & inten_i[i]; status[i] appears one cycle after the gpio_val_o change.
// - irq_o = |intstatus_o, registered in the same cycle as status (no extra latency).
// - Clear: stat_clr_i clears all status bits on the next edge.
// - Clear vs set in the same cycle: set wins for that pin (no lost event); other pins clear.
// - A level-type pin whose level persists re-asserts status the cycle after a clear.
// - Dropping inten_i[i] masks new events only; an already-set status[i] is kept until cleared.
// - Changing inttype mid-operation takes effect the next cycle; no flush and no spurious clear.
// - Asserting rst_n_i mid-operation clears everything immediately and re-arms the edge suppression.
// CONFIGURATION
// - Macro GPIO_DEBOUNCE_EN, defined: per-pin debounce after the synchroniser.
//   - The debounced value updates only after the synced value differs from it for dbnc_cnt_i consecutive cycles.
//   - The counter resets to 0 whenever the synced value equals the debounced value again (glitch rejected).
//   - dbnc_cnt_i=0 bypasses debounce: latency is identical to the undefined case.
//   - Counter width is DBNC_CNT_W; the count saturates at dbnc_cnt_i and never wraps.
//   - Edge detection and gpio_val_o use the debounced value.
// - Macro GPIO_DEBOUNCE_EN, undefined: the dbnc_cnt_i port and DBNC_CNT_W logic are absent; gpio_val_o = synchroniser output.
// STRUCTURE
// - Shared package gpio_pkg:
//   - typedef enum logic [1:0] gpio_inttype_e {RISE=2'b00, FALL=2'b01, HIGH=2'b10, LOW=2'b11}.
//   - localparam GPIO_SYNC_STAGES_MAX = 4.
// - Sub-module gpio_dbnc: one pin, counter + debounced-value reg, instantiated GPIO_NUM times in a generate loop under GPIO_DEBOUNCE_EN.
// - Synchroniser, edge detect, arm counter and status regs live in gpio_in_cond itself.
// TESTING
// - Rising-edge interrupt: type=00, inten[3]=1, pin3 0->1 at cycle 10 -> gpio_val_o[3]=1 at cycle 12, intstatus_o=8'h08 and irq_o=1 at cycle 13.
// - Clear with concurrent set: status=8'h08, stat_clr_i pulse in the same cycle as a new pin5 rising event with inten[5]=1 -> status=8'h20, irq_o stays 1.
// - Level-low re-assert: type=11 on pin0, pin held 0, status cleared -> status[0]=1 again one cycle after the clear; pin0 set 1, then clear -> stays 0.
// - Reset with pin high: pin7=1 through reset release, type=00, inten=8'hFF -> intstatus_o stays 0 for 20 cycles, gpio_val_o[7]=1 after 2 cycles.
// - Masking: inten=0, falling edges on all pins -> status=0, irq_o=0; status=8'h01 then inten[0]=0 -> status stays 8'h01 until the clear.
// - Debounce (GPIO_DEBOUNCE_EN, dbnc_cnt_i=4):
//   - 3-cycle high glitch on pin2 -> gpio_val_o[2] stays 0, no event.
//   - 6-cycle high pulse on pin2 -> gpio_val_o[2]=1 after 4 stable cycles; one rising event.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and limits for the GPIO input-conditioning path.
package gpio_pkg;

  typedef enum logic [1:0] {
    RISE = 2'b00,
    FALL = 2'b01,
    HIGH = 2'b10,
    LOW  = 2'b11
  } gpio_inttype_e;

  localparam int GPIO_SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/gpio_dbnc.sv
// Single-pin debouncer: the output follows the input only after it has
// differed for thr_i consecutive cycles; thr_i == 0 is a transparent bypass.
module gpio_dbnc #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_i,
  input  logic [W-1:0] thr_i,
  output logic         val_o
);

  logic [W-1:0] cnt_q;
  logic         db_q;
  logic         reached;

  // Widened compare so the count can never wrap past the threshold.
  assign reached = ({1'b0, cnt_q} + {{W{1'b0}}, 1'b1}) >= {1'b0, thr_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (thr_i == '0 || in_i == db_q) begin
      cnt_q <= '0;
      db_q  <= in_i;
    end else if (reached) begin
      cnt_q <= '0;
      db_q  <= in_i;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign val_o = (thr_i == '0) ? in_i : db_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// per-pin edge/level event detect, sticky interrupt status and irq.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int GPIO_NUM    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [GPIO_NUM-1:0]   gpio_in_i,
  input  logic [GPIO_NUM-1:0]   inten_i,
  input  logic [GPIO_NUM-1:0]   inttype0_i,
  input  logic [GPIO_NUM-1:0]   inttype1_i,
  input  logic                  stat_clr_i,
`ifdef GPIO_DEBOUNCE_EN
  input  logic [DBNC_CNT_W-1:0] dbnc_cnt_i,
`endif
  output logic [GPIO_NUM-1:0]   gpio_val_o,
  output logic [GPIO_NUM-1:0]   intstatus_o,
  output logic                  irq_o
);

  localparam int ARM_W = $clog2(GPIO_SYNC_STAGES_MAX + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);

  logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_NUM-1:0] val;
  logic [GPIO_NUM-1:0] prev_q;
  logic [GPIO_NUM-1:0] status_q;
  logic [GPIO_NUM-1:0] status_next;
  logic [GPIO_NUM-1:0] event_vec;
  logic [ARM_W-1:0]    arm_cnt_q;
  logic                armed;
  logic                irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_dbnc
    gpio_dbnc #(.W(DBNC_CNT_W)) u_dbnc (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .in_i    (sync_q[SYNC_STAGES-1][i]),
      .thr_i   (dbnc_cnt_i),
      .val_o   (val[i])
    );
  end
`else
  assign val = sync_q[SYNC_STAGES-1];
`endif

  // Edge events stay masked until the synchroniser has flushed its reset zeros.
  assign armed = (arm_cnt_q == ARM_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      arm_cnt_q <= '0;
      prev_q    <= '0;
    end else begin
      if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
      prev_q <= val;
    end
  end

  always_comb begin
    event_vec = '0;
    for (int i = 0; i < GPIO_NUM; i++) begin
      case (gpio_inttype_e'({inttype1_i[i], inttype0_i[i]}))
        RISE:    event_vec[i] = armed & val[i] & ~prev_q[i];
        FALL:    event_vec[i] = armed & ~val[i] & prev_q[i];
        HIGH:    event_vec[i] = val[i];
        LOW:     event_vec[i] = ~val[i];
        default: event_vec[i] = 1'b0;
      endcase
    end
  end

  // A new event wins over a concurrent clear for its own pin.
  assign status_next = (stat_clr_i ? '0 : status_q) | (event_vec & inten_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_next;
      irq_q    <= |status_next;
    end
  end

  assign gpio_val_o  = val;
  assign intstatus_o = status_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed + randomised bench for gpio_in_cond; expected {irq, status, val}
// words are queued as stimulus is driven and compared when sampled.
module tb_gpio_in_cond;

  logic        clk;
  logic        rst_n;
  logic [7:0]  gpio_in;
  logic [7:0]  inten;
  logic [7:0]  inttype0;
  logic [7:0]  inttype1;
  logic        stat_clr;
  logic [15:0] dbnc_cnt;
  logic [7:0]  gpio_val;
  logic [7:0]  intstatus;
  logic        irq;

  logic [16:0] exp_q[$];
  int          n_vec;
  int          n_bad;

  gpio_in_cond #(.GPIO_NUM(8), .SYNC_STAGES(2), .DBNC_CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .gpio_in_i   (gpio_in),
    .inten_i     (inten),
    .inttype0_i  (inttype0),
    .inttype1_i  (inttype1),
    .stat_clr_i  (stat_clr),
`ifdef GPIO_DEBOUNCE_EN
    .dbnc_cnt_i  (dbnc_cnt),
`endif
    .gpio_val_o  (gpio_val),
    .intstatus_o (intstatus),
    .irq_o       (irq)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
  endtask

  task automatic push_exp(input logic e_irq, input logic [7:0] e_stat, input logic [7:0] e_val);
    exp_q.push_back({e_irq, e_stat, e_val});
  endtask

  // scoreboard
  task automatic check_vec(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed irq=%0b stat=%02h val=%02h, expected irq=%0b stat=%02h val=%02h",
               tag, obs[16], obs[15:8], obs[7:0], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic sample(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: observed empty expectation queue, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_vec(tag, {irq, intstatus, gpio_val}, e);
    end
  endtask

  initial begin
    logic [7:0] m;
    int p;
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    gpio_in  = '0;
    inten    = '0;
    inttype0 = '0;
    inttype1 = '0;
    stat_clr = 1'b0;
    dbnc_cnt = '0;

    tick(1);
    push_exp(0, 8'h00, 8'h00); sample("reset");
    rst_n = 1'b1;
    tick(10);

    // rising edge on pin3
    inten = 8'h08;
    gpio_in[3] = 1'b1;
    tick(1); push_exp(0, 8'h00, 8'h00); sample("rise_sync1");
    tick(1); push_exp(0, 8'h00, 8'h08); sample("rise_val");
    tick(1); push_exp(1, 8'h08, 8'h08); sample("rise_stat");

    // clear concurrent with a new pin5 event
    inten = 8'h28;
    gpio_in[5] = 1'b1;
    tick(2); push_exp(1, 8'h08, 8'h28); sample("clrset_pre");
    clear_pulse(); push_exp(1, 8'h20, 8'h28); sample("clrset_win");

    // level-low on pin0
    inten = 8'h01;
    inttype0 = 8'h01;
    inttype1 = 8'h01;
    tick(1); push_exp(1, 8'h21, 8'h28); sample("low_set");
    clear_pulse(); push_exp(1, 8'h01, 8'h28); sample("low_reassert");
    tick(1); push_exp(1, 8'h01, 8'h28); sample("low_hold");
    gpio_in[0] = 1'b1;
    tick(2); push_exp(1, 8'h01, 8'h29); sample("low_pin_high");
    clear_pulse(); push_exp(0, 8'h00, 8'h29); sample("low_cleared");
    tick(1); push_exp(0, 8'h00, 8'h29); sample("low_stays_clr");

    // masking with falling type
    inten = 8'h00;
    inttype0 = 8'hFF;
    inttype1 = 8'h00;
    gpio_in = 8'h00;
    tick(3); push_exp(0, 8'h00, 8'h00); sample("mask_fall");
    gpio_in[0] = 1'b1;
    tick(3); push_exp(0, 8'h00, 8'h01); sample("mask_rise_ign");
    inten = 8'h01;
    gpio_in[0] = 1'b0;
    tick(2); push_exp(0, 8'h00, 8'h00); sample("fall_val");
    tick(1); push_exp(1, 8'h01, 8'h00); sample("fall_stat");
    inten = 8'h00;
    tick(5); push_exp(1, 8'h01, 8'h00); sample("mask_keep");
    clear_pulse(); push_exp(0, 8'h00, 8'h00); sample("mask_clr");

    // random single-pin rising events
    inttype0 = 8'h00;
    inten = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      p = int'($urandom_range(0, 7));
      m = 8'h01 << p;
      gpio_in = m;
      tick(2); push_exp(0, 8'h00, m); sample("rnd_val");
      tick(1); push_exp(1, m, m); sample("rnd_stat");
      gpio_in = 8'h00;
      clear_pulse(); push_exp(0, 8'h00, m); sample("rnd_clr");
      tick(2); push_exp(0, 8'h00, 8'h00); sample("rnd_idle");
    end

    // reset mid-operation with pin7 held high
    gpio_in = 8'h80;
    tick(3);
    rst_n = 1'b0;
    #1; push_exp(0, 8'h00, 8'h00); sample("rst_async");
    tick(2); push_exp(0, 8'h00, 8'h00); sample("rst_hold");
    rst_n = 1'b1;
    tick(1); push_exp(0, 8'h00, 8'h00); sample("rel_sync1");
    tick(1); push_exp(0, 8'h00, 8'h80); sample("rel_val");
    for (int k = 0; k < 18; k++) begin
      tick(1); push_exp(0, 8'h00, 8'h80); sample("rel_no_evt");
    end
    gpio_in = 8'h00;
    tick(3);
    gpio_in = 8'h80;
    tick(2); push_exp(0, 8'h00, 8'h80); sample("rearm_val");
    tick(1); push_exp(1, 8'h80, 8'h80); sample("rearm_stat");

`ifdef GPIO_DEBOUNCE_EN
    gpio_in = 8'h00;
    clear_pulse();
    dbnc_cnt = 16'd4;
    inten = 8'h04;
    tick(8); push_exp(0, 8'h00, 8'h00); sample("db_idle");
    gpio_in = 8'h04;
    tick(3);
    gpio_in = 8'h00;
    tick(6); push_exp(0, 8'h00, 8'h00); sample("db_glitch");
    gpio_in = 8'h04;
    tick(5); push_exp(0, 8'h00, 8'h00); sample("db_wait");
    tick(1); push_exp(0, 8'h00, 8'h04); sample("db_val");
    gpio_in = 8'h00;
    tick(1); push_exp(1, 8'h04, 8'h04); sample("db_stat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
